instr_fetch: RTL and testbench

//  Fetch stage sitting directly downstream of the instruction memory: owns the PC, drives the

---
 rtl/core_pkg.sv | 33 +++
 rtl/instr_fetch_if.sv | 56 +++++
 rtl/fetch_queue.sv | 75 +++++++
 rtl/instr_fetch.sv | 141 ++++++++++++++
 tb/tb_instr_fetch.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
//   Types and default constants shared by the front end of the core
//   (fetch, decode, branch unit).
//
//   fetch_state_t   fetch-stage control state: IDLE / RUN / HALTED
//   DEF_DATA_WIDTH  default instruction width
//   DEF_ADDR_WIDTH  default instruction-memory word-address width
//   PC_W            byte-PC width for the default address width
//   DEF_HALT_INSN   opcode that stops the fetch stage
//   DEF_RESET_PC    byte PC loaded on reset
// ---------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int PC_W           = DEF_ADDR_WIDTH + 2;

  localparam logic [31:0]     DEF_HALT_INSN = 32'h0000_0073;
  localparam logic [PC_W-1:0] DEF_RESET_PC  = '0;

  // Byte PC of the next sequential instruction; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] next_seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
//   Bus bundle around the fetch stage: the instruction-memory read port,
//   the branch redirect input and the valid/ready channel toward decode.
//
//   imem_addr       word address to instruction memory
//   imem_data       instruction word, returned combinationally
//   redirect_valid  taken branch/jump: flush and restart
//   redirect_pc     new byte PC (low two bits ignored)
//   if_valid        queue head valid toward decode
//   if_ready        decode accepts the head
//   if_instr        head instruction
//   if_pc           head byte PC
//
//   modport master : the fetch stage
//   modport slave  : memory / decode / branch side
// ---------------------------------------------------------------------------
interface instr_fetch_if
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH+1:0] redirect_pc;
  logic                  if_valid;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH+1:0] if_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Small synchronous FIFO holding {pc, instr} pairs between fetch and
//   decode. Pointers carry one extra wrap bit so full and empty are told
//   apart without a separate counter register. The head is read straight
//   out of the storage array so a word written this cycle is visible at
//   the output on the next cycle.
//
//   clk      clock
//   rst_n    asynchronous active-low reset (pointers only)
//   flush    drop every entry; wins over push and pop
//   push     write wr_data at the tail (ignored when full without a pop)
//   pop      retire the head (ignored when empty)
//   wr_data  entry to write
//   rd_data  current head entry (don't-care when empty)
//   count    number of valid entries, 0..DEPTH
//   full     count == DEPTH
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter  int WIDTH = 44,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [PTR_W:0]   count,
  output logic             full
);

  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;
  logic             push_ok;
  logic             pop_ok;

  assign wr_idx = wr_ptr_reg[PTR_W-1:0];
  assign rd_idx = rd_ptr_reg[PTR_W-1:0];

  assign count = wr_ptr_reg - rd_ptr_reg;
  // Same slot, opposite lap: the writer is a whole buffer ahead.
  assign full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) && (wr_idx == rd_idx);

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign pop_ok  = pop  & (count != '0);
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed once counted valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Fetch stage directly behind the instruction memory. Owns the PC,
//   drives the memory read address, captures the combinationally returned
//   word and queues {pc, instr} pairs toward decode. Handles branch
//   redirect, fetch enable, the halt opcode and a retired-fetch counter.
//
//   clk        clock
//   rst_n      asynchronous active-low reset
//   fetch_en   1 = new fetches allowed; 0 = stop fetching, queue drains
//   bus        instr_fetch_if.master: imem port, redirect, decode channel
//   halted     state is HALTED (registered)
//   fetch_cnt  instructions accepted by decode, saturating
// ---------------------------------------------------------------------------
module instr_fetch
  import core_pkg::*;
#(
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    Q_DEPTH    = 2,
  parameter logic [ADDR_WIDTH+1:0] RESET_PC   = (ADDR_WIDTH+2)'(DEF_RESET_PC),
  parameter logic [DATA_WIDTH-1:0] HALT_INSN  = DATA_WIDTH'(DEF_HALT_INSN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fetch_en,
  instr_fetch_if.master       bus,
  output logic                halted,
  output logic [31:0]         fetch_cnt
);

  localparam int PCW   = ADDR_WIDTH + 2;
  localparam int QW    = PCW + DATA_WIDTH;
  localparam int CNT_W = $clog2(Q_DEPTH) + 1;

  fetch_state_t     state_reg;
  logic [PCW-1:0]   pc_reg;
  logic             halted_reg;
  logic [31:0]      fetch_cnt_reg;

  logic [QW-1:0]    q_head;
  logic [CNT_W-1:0] q_count;
  logic             q_full;

  logic             pop;
  logic             push;
  logic             push_is_halt;
  logic             fetch_stop;
  logic [PCW-1:0]   redirect_target;
  logic [PCW-1:0]   pc_inc;
  fetch_state_t     redirect_state;

  // ---------------------------------------------------------------------
  // Datapath toward memory and decode
  // ---------------------------------------------------------------------
  assign bus.imem_addr = pc_reg[ADDR_WIDTH+1:2];

  // A redirect kills the head combinationally so decode never takes a
  // wrong-path instruction in the cycle the branch resolves.
  assign bus.if_valid = (q_count != '0) & ~bus.redirect_valid;
  assign pop          = bus.if_valid & bus.if_ready;

  assign push = (state_reg == RUN) & ~bus.redirect_valid & (~q_full | pop);

  assign push_is_halt    = push & (bus.imem_data == HALT_INSN);
  assign fetch_stop      = ~fetch_en;
  assign redirect_target = bus.redirect_pc & ~PCW'(3);
  assign pc_inc          = pc_reg + PCW'(4);
  assign redirect_state  = fetch_en ? RUN : IDLE;

  assign {bus.if_pc, bus.if_instr} = q_head;

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (Q_DEPTH)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (bus.redirect_valid),
    .push    (push),
    .pop     (pop),
    .wr_data ({pc_reg, bus.imem_data}),
    .rd_data (q_head),
    .count   (q_count),
    .full    (q_full)
  );

  // ---------------------------------------------------------------------
  // Control FSM and PC. Redirect outranks everything; the halt opcode is
  // queued like any other word and then blocks further pushes.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      halted_reg <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_reg     <= redirect_target;
      state_reg  <= redirect_state;
      halted_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (fetch_en) state_reg <= RUN;
        end
        RUN: begin
          // The cycle in which fetch_en drops still fetches.
          if (push) pc_reg <= pc_inc;
          if (push_is_halt) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end else if (fetch_stop) begin
            state_reg  <= IDLE;
          end
        end
        HALTED: begin
          state_reg <= HALTED;
        end
        default: begin
          state_reg  <= IDLE;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Retired-fetch counter, saturating at all ones
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_reg <= '0;
    end else if (pop && !(&fetch_cnt_reg)) begin
      fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
    end
  end

  assign halted    = halted_reg;
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. Instruction memory is a combinational
//   array with mem[i] = 32'h1000_0000 + i. Inputs change 1 ns after the
//   rising edge; outputs are sampled there as well.
// ---------------------------------------------------------------------------
module tb_instr_fetch;
  import core_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic        halted;
  logic [31:0] fetch_cnt;

  logic [DW-1:0] mem [1 << AW];

  int total = 0;
  int bad   = 0;

  instr_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  instr_fetch #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .Q_DEPTH    (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .bus       (bus),
    .halted    (halted),
    .fetch_cnt (fetch_cnt)
  );

  always #5 clk = ~clk;

  always_comb bus.imem_data = mem[bus.imem_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000_0000 + i;
    rst_n              = 1'b0;
    fetch_en           = 1'b0;
    bus.if_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) tick();

    // Reset state
    check("rst_valid",  64'(bus.if_valid),  64'(0));
    check("rst_halted", 64'(halted),        64'(0));
    check("rst_cnt",    64'(fetch_cnt),     64'(0));
    check("rst_addr",   64'(bus.imem_addr), 64'(0));

    // 1: sequential stream with decode always ready
    rst_n        = 1'b1;
    fetch_en     = 1'b1;
    bus.if_ready = 1'b1;
    tick();
    check("t1_first_idle", 64'(bus.if_valid), 64'(0));
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_valid", 64'(bus.if_valid), 64'(1));
      check("t1_pc",    64'(bus.if_pc),    64'(4 * i));
      check("t1_instr", 64'(bus.if_instr), 64'(32'h1000_0000 + i));
      tick();
    end
    check("t1_cnt", 64'(fetch_cnt), 64'(4));

    // 2: backpressure fills the queue, then drains in order
    bus.if_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    check("t2_full_valid", 64'(bus.if_valid),  64'(1));
    check("t2_full_pc",    64'(bus.if_pc),     64'(0));
    check("t2_addr_held",  64'(bus.imem_addr), 64'(2));
    check("t2_cnt0",       64'(fetch_cnt),     64'(0));
    bus.if_ready = 1'b1;
    tick();
    check("t2_pc4",    64'(bus.if_pc),     64'(4));
    check("t2_addr3",  64'(bus.imem_addr), 64'(3));
    tick();
    check("t2_pc8",    64'(bus.if_pc),     64'(8));
    check("t2_instr8", 64'(bus.if_instr),  64'(32'h1000_0002));
    check("t2_cnt2",   64'(fetch_cnt),     64'(2));

    // 3: redirect while full kills the head and restarts at 0x100
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 12'h103;
    #1;
    check("t3_kill_valid", 64'(bus.if_valid), 64'(0));
    tick();
    bus.redirect_valid = 1'b0;
    check("t3_empty",      64'(bus.if_valid),  64'(0));
    check("t3_addr",       64'(bus.imem_addr), 64'(12'h100 >> 2));
    tick();
    check("t3_valid",      64'(bus.if_valid), 64'(1));
    check("t3_pc",         64'(bus.if_pc),    64'(12'h100));
    check("t3_instr",      64'(bus.if_instr), 64'(32'h1000_0040));
    check("t3_cnt",        64'(fetch_cnt),    64'(2));

    // 4: halt opcode at word 5
    mem[5] = DEF_HALT_INSN;
    do_reset();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_pc", 64'(bus.if_pc), 64'(4 * i));
      tick();
    end
    check("t4_halt_pc",    64'(bus.if_pc),    64'(12'h014));
    check("t4_halt_instr", 64'(bus.if_instr), 64'(32'h0000_0073));
    check("t4_halted",     64'(halted),       64'(1));
    tick();
    check("t4_no_more",    64'(bus.if_valid), 64'(0));
    tick();
    check("t4_still_off",  64'(bus.if_valid), 64'(0));
    check("t4_cnt",        64'(fetch_cnt),    64'(6));
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = '0;
    tick();
    bus.redirect_valid = 1'b0;
    mem[5] = 32'h1000_0005;
    check("t4_resume_halted", 64'(halted), 64'(0));
    tick();
    check("t4_resume_valid",  64'(bus.if_valid), 64'(1));
    check("t4_resume_pc",     64'(bus.if_pc),    64'(0));

    // 5: redirect to the last word wraps the PC to 0
    do_reset();
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 12'hFFC;
    tick();
    bus.redirect_valid = 1'b0;
    check("t5_addr_last", 64'(bus.imem_addr), 64'(10'h3FF));
    tick();
    check("t5_pc_last",   64'(bus.if_pc),     64'(12'hFFC));
    check("t5_instr",     64'(bus.if_instr),  64'(32'h1000_03FF));
    check("t5_addr_wrap", 64'(bus.imem_addr), 64'(0));
    tick();
    check("t5_pc_wrap",   64'(bus.if_pc),     64'(0));
    check("t5_instr0",    64'(bus.if_instr),  64'(32'h1000_0000));

    // 6: asynchronous reset mid-stream
    do_reset();
    repeat (4) tick();
    check("t6_pre_pc",  64'(bus.if_pc), 64'(8));
    check("t6_pre_cnt", 64'(fetch_cnt), 64'(2));
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(bus.if_valid),  64'(0));
    check("t6_async_cnt",   64'(fetch_cnt),     64'(0));
    check("t6_async_addr",  64'(bus.imem_addr), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    check("t6_restart_valid", 64'(bus.if_valid), 64'(1));
    check("t6_restart_pc",    64'(bus.if_pc),    64'(0));

    // fetch_en drop: this cycle still fetches pc 4, then the PC holds
    fetch_en = 1'b0;
    tick();
    check("t7_last_pc",  64'(bus.if_pc),     64'(4));
    check("t7_addr",     64'(bus.imem_addr), 64'(2));
    tick();
    check("t7_drained",  64'(bus.if_valid),  64'(0));
    check("t7_addr_hold", 64'(bus.imem_addr), 64'(2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
